// File: rtl/mm2s_lite_slave_pkg.sv
// Shared definitions for the MM2S AXI-Lite register slave: register offsets, bit positions,
// FSM encoding and the LENGTH-to-beat conversion.
package mm2s_lite_slave_pkg;

    localparam int unsigned OFF_DMACR  = 32'h00;
    localparam int unsigned OFF_DMASR  = 32'h04;
    localparam int unsigned OFF_SA     = 32'h18;
    localparam int unsigned OFF_MSB    = 32'h1C;
    localparam int unsigned OFF_LEN    = 32'h28;

    localparam int unsigned BIT_RS     = 0;
    localparam int unsigned BIT_RESET  = 2;
    localparam int unsigned BIT_IOC    = 12;
    localparam int unsigned BIT_HALTED = 0;
    localparam int unsigned BIT_IDLE   = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mm2s_state_e;

    // Number of 32-bit beats covering len bytes; a full 2^24 count wraps to 0 and the
    // down-counter still yields 2^24 beats.
    function automatic logic [23:0] beats_of(input logic [31:0] len);
        return 24'((len + 32'd3) >> 2);
    endfunction

endpackage

// File: rtl/mm2s_stream_gen.sv
// Beat generator: walks a 64-bit byte address in 4-byte steps and emits one AXI-Stream
// beat per step until the beat count is exhausted or a stop request is seen.
module mm2s_stream_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic [23:0] i_beats,
    input  logic [63:0] i_addr,
    input  logic        i_stop,
    input  logic        i_tready,
    output logic        o_tvalid,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_hs,
    output logic        o_last_hs
);

    logic        r_active;
    logic [23:0] r_count;
    logic [63:0] r_addr;
    logic        w_hs;
    logic        w_final;

    assign w_hs    = r_active & i_tready;
    assign w_final = (r_count == 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_addr   <= '0;
        end else if (i_clear) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_addr   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= i_beats;
            r_addr   <= i_addr;
        end else if (w_hs) begin
            r_count <= r_count - 24'd1;
            r_addr  <= r_addr + 64'd4;
            if (w_final || i_stop) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_tvalid  = r_active;
    assign o_tdata   = r_addr[31:0];
    assign o_tlast   = r_active & w_final;
    assign o_hs      = w_hs;
    assign o_last_hs = w_hs & w_final;

endmodule

// File: rtl/mm2s_lite_slave.sv
// AXI-Lite slave for the MM2S DMA register subset; a LENGTH write launches an address stream
// and completion raises the IOC interrupt.
module mm2s_lite_slave
    import mm2s_lite_slave_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
    input  logic              s_axi_lite_awvalid,
    output logic              s_axi_lite_awready,
    input  logic [31:0]       s_axi_lite_wdata,
    input  logic              s_axi_lite_wvalid,
    output logic              s_axi_lite_wready,
    output logic [1:0]        s_axi_lite_bresp,
    output logic              s_axi_lite_bvalid,
    input  logic              s_axi_lite_bready,
    input  logic [ADDR_W-1:0] s_axi_lite_araddr,
    input  logic              s_axi_lite_arvalid,
    output logic              s_axi_lite_arready,
    output logic [31:0]       s_axi_lite_rdata,
    output logic [1:0]        s_axi_lite_rresp,
    output logic              s_axi_lite_rvalid,
    input  logic              s_axi_lite_rready,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              mm2s_introut
);

    localparam logic [ADDR_W-1:0] A_DMACR = ADDR_W'(OFF_DMACR);
    localparam logic [ADDR_W-1:0] A_DMASR = ADDR_W'(OFF_DMASR);
    localparam logic [ADDR_W-1:0] A_SA    = ADDR_W'(OFF_SA);
    localparam logic [ADDR_W-1:0] A_MSB   = ADDR_W'(OFF_MSB);
    localparam logic [ADDR_W-1:0] A_LEN   = ADDR_W'(OFF_LEN);

    // AXI-Lite handshake state
    logic              r_out_en;
    logic              r_aw_held;
    logic [ADDR_W-1:0] r_aw_addr;
    logic              r_w_held;
    logic [31:0]       r_w_data;
    logic              r_bvalid;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rd_data;
    logic              w_wr_fire;

    // Register file
    logic              r_rs, w_rs_d;
    logic              r_irq_en, w_irq_en_d;
    logic              r_soft_rst, w_soft_rst_d;
    logic              r_halted, w_halted_d;
    logic              r_idle, w_idle_d;
    logic              r_ioc, w_ioc_d;
    logic [31:0]       r_sa, w_sa_d;
    logic [31:0]       r_msb, w_msb_d;
    logic [LEN_W-1:0]  r_len, w_len_d;
    logic [LEN_W-1:0]  w_len_wr;
    logic [23:0]       w_beats;
    logic              w_start;

    mm2s_state_e       r_state, w_state_d;
    logic              w_fsm_idle;
    logic              w_fsm_done;
    logic              w_stream_hs;
    logic              w_stream_last_hs;

    assign w_wr_fire = r_aw_held & r_w_held;
    assign w_len_wr  = r_w_data[LEN_W-1:0];
    assign w_beats   = beats_of(32'(w_len_wr));

    assign s_axi_lite_awready = r_out_en & ~r_aw_held & ~r_bvalid;
    assign s_axi_lite_wready  = r_out_en & ~r_w_held & ~r_bvalid;
    assign s_axi_lite_arready = r_out_en & ~r_rvalid;
    assign s_axi_lite_bvalid  = r_bvalid;
    assign s_axi_lite_rvalid  = r_rvalid;
    assign s_axi_lite_rdata   = r_rdata;
    assign s_axi_lite_bresp   = RESP_OKAY;
    assign s_axi_lite_rresp   = RESP_OKAY;
    assign mm2s_introut       = r_ioc & r_irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en  <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_out_en <= 1'b1;
            if (s_axi_lite_awready && s_axi_lite_awvalid) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_axi_lite_awaddr;
            end
            if (s_axi_lite_wready && s_axi_lite_wvalid) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi_lite_wdata;
            end
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else if (r_bvalid && s_axi_lite_bready) begin
                r_bvalid <= 1'b0;
            end
            if (s_axi_lite_arready && s_axi_lite_arvalid) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && s_axi_lite_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (s_axi_lite_araddr)
            A_DMACR: begin
                w_rd_data[BIT_RS]    = r_rs;
                w_rd_data[BIT_RESET] = r_soft_rst;
                w_rd_data[BIT_IOC]   = r_irq_en;
            end
            A_DMASR: begin
                w_rd_data[BIT_HALTED] = r_halted;
                w_rd_data[BIT_IDLE]   = r_idle;
                w_rd_data[BIT_IOC]    = r_ioc;
            end
            A_SA:    w_rd_data = r_sa;
            A_MSB:   w_rd_data = r_msb;
            A_LEN:   w_rd_data = 32'(r_len);
            default: w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_rs_d       = r_rs;
        w_irq_en_d   = r_irq_en;
        w_soft_rst_d = 1'b0;
        w_halted_d   = r_halted;
        w_idle_d     = r_idle;
        w_ioc_d      = r_ioc;
        w_sa_d       = r_sa;
        w_msb_d      = r_msb;
        w_len_d      = r_len;
        w_start      = 1'b0;
        if (!r_rs && w_fsm_idle) begin
            w_halted_d = 1'b1;
        end
        if (w_wr_fire) begin
            case (r_aw_addr)
                A_DMACR: begin
                    w_rs_d       = r_w_data[BIT_RS];
                    w_irq_en_d   = r_w_data[BIT_IOC];
                    w_soft_rst_d = r_w_data[BIT_RESET];
                    if (r_w_data[BIT_RS]) begin
                        w_halted_d = 1'b0;
                    end
                end
                A_DMASR: begin
                    if (r_w_data[BIT_IOC]) begin
                        w_ioc_d = 1'b0;
                    end
                end
                A_SA:  w_sa_d  = r_w_data;
                A_MSB: w_msb_d = r_w_data;
                A_LEN: begin
                    if (w_fsm_idle) begin
                        w_len_d = w_len_wr;
                        if (w_len_wr == '0) begin
                            w_idle_d = 1'b1;
                            w_ioc_d  = 1'b1;
                        end else if (r_rs && !r_halted) begin
                            w_start  = 1'b1;
                            w_idle_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Completion set takes priority over a simultaneous W1C.
        if (w_fsm_done) begin
            w_idle_d = 1'b1;
            w_ioc_d  = 1'b1;
        end
        if (r_soft_rst) begin
            w_rs_d     = 1'b0;
            w_irq_en_d = 1'b0;
            w_halted_d = 1'b1;
            w_idle_d   = 1'b0;
            w_ioc_d    = 1'b0;
            w_sa_d     = '0;
            w_msb_d    = '0;
            w_len_d    = '0;
            w_start    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_soft_rst <= 1'b0;
            r_halted   <= 1'b1;
            r_idle     <= 1'b0;
            r_ioc      <= 1'b0;
            r_sa       <= '0;
            r_msb      <= '0;
            r_len      <= '0;
        end else begin
            r_rs       <= w_rs_d;
            r_irq_en   <= w_irq_en_d;
            r_soft_rst <= w_soft_rst_d;
            r_halted   <= w_halted_d;
            r_idle     <= w_idle_d;
            r_ioc      <= w_ioc_d;
            r_sa       <= w_sa_d;
            r_msb      <= w_msb_d;
            r_len      <= w_len_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_start) w_state_d = StBusy;
            StBusy: begin
                // Clearing RS mid-transfer abandons the rest without signalling completion.
                if (w_stream_hs && !r_rs) begin
                    w_state_d = StIdle;
                end else if (w_stream_last_hs) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (r_soft_rst) begin
            w_state_d = StIdle;
        end
    end

    always_comb begin
        w_fsm_idle = 1'b0;
        w_fsm_done = 1'b0;
        unique case (r_state)
            StIdle:  w_fsm_idle = 1'b1;
            StBusy:  ;
            StDone:  w_fsm_done = 1'b1;
            default: ;
        endcase
    end

    mm2s_stream_gen u_stream_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_soft_rst),
        .i_start   (w_start),
        .i_beats   (w_beats),
        .i_addr    ({r_msb, r_sa}),
        .i_stop    (~r_rs),
        .i_tready  (m_axis_tready),
        .o_tvalid  (m_axis_tvalid),
        .o_tdata   (m_axis_tdata),
        .o_tlast   (m_axis_tlast),
        .o_hs      (w_stream_hs),
        .o_last_hs (w_stream_last_hs)
    );

endmodule

// File: tb/tb_mm2s_lite_slave.sv
// Directed bench for mm2s_lite_slave: register accesses over AXI-Lite with a scoreboard
// of expected stream beats and register read data.
module tb_mm2s_lite_slave;

    logic        clk;
    logic        rst;
    logic [9:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [9:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        introut;

    int          n_vec;
    int          n_err;
    int          b_rises;
    int          tr_mode;
    logic [32:0] sb[$];
    logic [31:0] rd_q[$];

    mm2s_lite_slave #(
        .ADDR_W (10),
        .LEN_W  (26)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready),
        .m_axis_tdata       (tdata),
        .m_axis_tvalid      (tvalid),
        .m_axis_tready      (tready),
        .m_axis_tlast       (tlast),
        .mm2s_introut       (introut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // tready pattern: 0 = held high, 1 = toggling, 2 = held low
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tr_mode == 0)      tready = 1'b1;
            else if (tr_mode == 1) tready = ~tready;
            else                   tready = 1'b0;
        end
    end

    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_b;

    always @(negedge clk) begin
        if (bvalid && !prev_b) b_rises++;
        prev_b = bvalid;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", 64'(tvalid), 64'd1);
                check("stall_tdata", 64'(tdata), 64'(prev_data));
            end
            if (tvalid && tready) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL stream_extra_beat: observed beat %0h, expected none", tdata);
                end
                if (sb.size() != 0) begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check("stream_beat", 64'({tlast, tdata}), 64'(e));
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
    end

    task automatic axi_write(input logic [9:0] a, input logic [31:0] d);
        int   t;
        logic aw_go;
        logic w_go;
        logic got;
        @(posedge clk);
        #1;
        awaddr = a; awvalid = 1'b1; wdata = d; wvalid = 1'b1; bready = 1'b1;
        t = 0;
        while ((awvalid || wvalid) && t < 20) begin
            @(negedge clk);
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk);
            #1;
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0;
        t = 0;
        while (!got && t < 20) begin
            @(negedge clk);
            if (bvalid) got = 1'b1;
            else t++;
        end
        @(posedge clk);
        #1;
        bready = 1'b0;
        check("wr_bvalid", 64'(got), 64'd1);
    endtask

    task automatic axi_read_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
        int          t;
        logic        go;
        logic        got;
        logic [31:0] data;
        rd_q.push_back(exp);
        @(posedge clk);
        #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (arvalid && t < 20) begin
            @(negedge clk);
            go = arready;
            @(posedge clk);
            #1;
            if (go) arvalid = 1'b0;
            t++;
        end
        arvalid = 1'b0;
        got = 1'b0; data = '0; t = 0;
        while (!got && t < 20) begin
            @(negedge clk);
            if (rvalid) begin
                got  = 1'b1;
                data = rdata;
            end else begin
                t++;
            end
        end
        @(posedge clk);
        #1;
        rready = 1'b0;
        check({tag, "_rvalid"}, 64'(got), 64'd1);
        check(tag, 64'(data), 64'(rd_q.pop_front()));
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; b_rises = 0; tr_mode = 0;
        prev_stall = 1'b0; prev_data = '0; prev_b = 1'b0;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_intr", 64'(introut), 64'd0);
        rst = 1'b0;
        axi_read_chk("rst_dmasr", 10'h04, 32'h0000_0001);

        // Basic 16-byte transfer with IOC enabled
        axi_write(10'h00, 32'h0000_1001);
        axi_write(10'h18, 32'h0000_1000);
        axi_write(10'h1C, 32'h0000_0000);
        for (int i = 0; i < 4; i++) sb.push_back({(i == 3), 32'h1000 + 32'(4 * i)});
        axi_write(10'h28, 32'd16);
        wait_drain("len16_drain");
        axi_read_chk("len16_dmasr", 10'h04, 32'h0000_1002);
        axi_read_chk("dmacr_rd", 10'h00, 32'h0000_1001);
        check("len16_intr", 64'(introut), 64'd1);

        // W1C of IOC
        axi_write(10'h04, 32'h0000_1000);
        check("w1c_intr", 64'(introut), 64'd0);
        axi_read_chk("w1c_dmasr", 10'h04, 32'h0000_0002);

        // Odd length under a toggling tready
        tr_mode = 1;
        sb.push_back({1'b0, 32'h1000});
        sb.push_back({1'b1, 32'h1004});
        axi_write(10'h28, 32'd5);
        wait_drain("len5_drain");
        tr_mode = 0;
        axi_read_chk("len5_len", 10'h28, 32'd5);
        axi_read_chk("len5_dmasr", 10'h04, 32'h0000_1002);
        axi_write(10'h04, 32'h0000_1000);

        // W ahead of AW by two cycles, AR while B is pending
        begin
            int b0;
            b0 = b_rises;
            @(posedge clk);
            #1;
            wdata = 32'h0000_2000; wvalid = 1'b1;
            @(negedge clk);
            check("early_wready", 64'(wready), 64'd1);
            @(posedge clk);
            #1;
            wvalid = 1'b0;
            @(posedge clk);
            #1;
            awaddr = 10'h18; awvalid = 1'b1;
            @(negedge clk);
            check("late_awready", 64'(awready), 64'd1);
            @(posedge clk);
            #1;
            awvalid = 1'b0;
            @(posedge clk);
            #1;
            araddr = 10'h18; arvalid = 1'b1; rready = 1'b1;
            @(negedge clk);
            check("pend_arready", 64'(arready), 64'd1);
            @(posedge clk);
            #1;
            arvalid = 1'b0;
            @(negedge clk);
            check("pend_rvalid", 64'(rvalid), 64'd1);
            check("pend_rdata", 64'(rdata), 64'h2000);
            check("pend_bvalid_hold", 64'(bvalid), 64'd1);
            @(posedge clk);
            #1;
            rready = 1'b0; bready = 1'b1;
            @(posedge clk);
            #1;
            bready = 1'b0;
            @(negedge clk);
            check("pend_bvalid_drop", 64'(bvalid), 64'd0);
            check("pend_b_pulses", 64'(b_rises - b0), 64'd1);
        end

        // RS cleared while a 64-byte transfer is stalled
        axi_write(10'h18, 32'h0000_3000);
        tr_mode = 2;
        axi_write(10'h28, 32'd64);
        axi_write(10'h00, 32'h0000_1000);
        sb.push_back({1'b0, 32'h3000});
        tr_mode = 0;
        wait_drain("abort_drain");
        check("abort_tvalid", 64'(tvalid), 64'd0);
        axi_read_chk("abort_dmasr", 10'h04, 32'h0000_0001);
        check("abort_intr", 64'(introut), 64'd0);

        // Hard reset during BUSY
        axi_write(10'h00, 32'h0000_1001);
        tr_mode = 2;
        axi_write(10'h28, 32'd64);
        @(posedge clk);
        #1;
        check("busy_tvalid", 64'(tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("hrst_tvalid", 64'(tvalid), 64'd0);
        check("hrst_tdata", 64'(tdata), 64'd0);
        check("hrst_tlast", 64'(tlast), 64'd0);
        check("hrst_awready", 64'(awready), 64'd0);
        check("hrst_bvalid", 64'(bvalid), 64'd0);
        check("hrst_rvalid", 64'(rvalid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tr_mode = 0;
        axi_read_chk("hrst_dmasr", 10'h04, 32'h0000_0001);

        // Completion with the interrupt enable off, then enabled
        axi_write(10'h00, 32'h0000_0001);
        axi_write(10'h18, 32'h0000_0100);
        sb.push_back({1'b1, 32'h0000_0100});
        axi_write(10'h28, 32'd4);
        wait_drain("noirq_drain");
        axi_read_chk("noirq_dmasr", 10'h04, 32'h0000_1002);
        check("noirq_intr", 64'(introut), 64'd0);
        axi_write(10'h00, 32'h0000_1001);
        check("irqen_intr", 64'(introut), 64'd1);

        // Zero-length write signals completion immediately
        axi_write(10'h04, 32'h0000_1000);
        axi_write(10'h28, 32'd0);
        check("len0_intr", 64'(introut), 64'd1);
        check("len0_tvalid", 64'(tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mm2s_lite_slave.md
Name: mm2s_lite_slave

Overview:
- AXI-Lite slave implementing the MM2S register subset of the team's DMA read channel: control, status, source address, address MSB and length.
- Sits directly downstream of the MM2S AXI-Lite master controller: consumes its register writes and status reads.
- Writing LENGTH launches a transfer that emits an AXI-Stream of ceil(len/4) 32-bit beats.
- On completion it raises mm2s_introut back to the controller.

Parameters:
- ADDR_W, 10, AXI-Lite address width.
- LEN_W, 26, significant bits of LENGTH register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous assert, active-high, one clock domain.
- s_axi_lite_awaddr  in  10  write address.
- s_axi_lite_awvalid  in  1  write address valid.
- s_axi_lite_awready  out  1  write address ready.
- s_axi_lite_wdata  in  32  write data; byte strobes are not supported, every write is a full word.
- s_axi_lite_wvalid  in  1  write data valid.
- s_axi_lite_wready  out  1  write data ready.
- s_axi_lite_bresp  out  2  write response, always 2'b00.
- s_axi_lite_bvalid  out  1  write response valid.
- s_axi_lite_bready  in  1  write response ready.
- s_axi_lite_araddr  in  10  read address.
- s_axi_lite_arvalid  in  1  read address valid.
- s_axi_lite_arready  out  1  read address ready.
- s_axi_lite_rdata  out  32  read data.
- s_axi_lite_rresp  out  2  read response, always 2'b00.
- s_axi_lite_rvalid  out  1  read data valid.
- s_axi_lite_rready  in  1  read data ready.
- m_axis_tdata  out  32  stream data = current byte address, low 32 bits.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  final beat of the transfer.
- mm2s_introut  out  1  interrupt = DMASR.IOC_Irq & DMACR.IOC_IrqEn.

Behaviour:
- Reset (async, rst=1):
  - all ready/valid outputs 0; rdata 0; tdata 0; tlast 0; mm2s_introut 0.
  - DMACR=0, DMASR=0x0000_0001 (Halted=1, Idle=0).
  - SA, MSB, LENGTH = 0; FSM = IDLE.
- Register map (reads of unmapped addresses return 0; writes to unmapped addresses are accepted and dropped):
  - 0x00 DMACR: bit0 RS, bit2 Reset (self-clearing), bit12 IOC_IrqEn; all other bits read 0.
  - 0x04 DMASR: bit0 Halted (RO), bit1 Idle (RO), bit12 IOC_Irq (write-1-to-clear).
  - 0x18 SA.
  - 0x1C MSB.
  - 0x28 LENGTH: low LEN_W bits stored; upper bits read 0.
- Write channel:
  - awready=1 while no address is latched and bvalid=0; wready behaves the same way for data.
  - AW and W may be accepted in either order or in the same cycle.
  - The register update occurs in the cycle after both are held; bvalid rises that same cycle and holds until bready.
  - Single outstanding write only.
- Read channel:
  - arready=1 while rvalid=0.
  - On the AR handshake, rdata is registered and rvalid=1 on the next cycle; both hold until rready.
- RS/Halted:
  - Writing RS=1 clears Halted on the next cycle.
  - RS=0 while IDLE sets Halted=1.
  - RS=0 while BUSY finishes the current beat, then goes to IDLE with Halted=1 and no IOC.
- Reset bit:
  - Synchronous soft reset of the register file and FSM to reset values, taking one cycle.
  - Any in-flight AXI-Lite response completes normally.
- FSM:
  - IDLE --(LENGTH write with RS=1, Halted=0, len!=0)--> BUSY.
  - In BUSY, LENGTH writes are ignored.
  - LENGTH write with len=0 sets Idle=1 and sets IOC_Irq.
- BUSY:
  - beats = ceil(len/4), held in a 24-bit counter; addr = {MSB,SA}, 64-bit.
  - tvalid=1; tdata=addr[31:0]; on each tready the address advances by 4 and the counter decrements.
  - tlast=1 on the final beat; tvalid/tdata hold stable while tready=0.
  - After the final handshake: next state DONE.
- DONE (1 cycle): sets Idle=1 and IOC_Irq=1, then returns to IDLE.
- Idle clears when a transfer starts.
- mm2s_introut is combinational from registered bits.
- Carry into MSB on 64-bit address wrap is allowed; tdata wraps modulo 2^32.
- A W1C write and an IOC set in the same cycle: set wins.

Decomposition:
- Shared package:
  - register offsets (DMACR 0x00, DMASR 0x04, SA 0x18, MSB 0x1C, LEN 0x28);
  - bit indices RS=0, RESET=2, IOC=12, HALTED=0, IDLE=1;
  - FSM state encodings IDLE/BUSY/DONE;
  - OKAY=2'b00.
- One sub-module: mm2s_stream_gen (beat counter, address incrementer, tvalid/tlast generation).

Test Plan:
- Write DMACR=0x1001, SA=0x1000, MSB=0, LEN=16 with tready=1 → 4 beats, tdata 0x1000,0x1004,0x1008,0x100C; tlast on the 4th; DMASR reads 0x1002; mm2s_introut=1.
- After that transfer, write DMASR=0x1000 → introut=0 next cycle; DMASR reads 0x0002.
- LEN=5 with tready toggling every cycle → exactly 2 beats; tdata stable whenever tvalid=1 and tready=0.
- Present W two cycles before AW, and send AR during a pending B → correct register update; single bvalid pulse; rdata correct.
- RS=0 mid-transfer of LEN=64 → stream stops after the current beat; DMASR Halted=1; no interrupt. Assert rst during BUSY → all outputs 0 immediately; DMASR=0x1.
- IOC_IrqEn=0 with a completed transfer → DMASR.IOC=1 but mm2s_introut=0; then set DMACR bit12 → introut=1.
